// File: rtl/spi_mem_master.sv
// Host-side sequencer for the serial RAM slave: turns one parallel read/write
// request into an address frame and a data frame, and captures read bytes.
module spi_mem_master #(
  parameter int GAP        = 2,
  parameter int RD_LAT     = 1,
  parameter int ADDR_CACHE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       MOSI,
  output logic       SS_n,
  input  logic       MISO
);

  localparam int CMAX = (GAP > RD_LAT) ? GAP : RD_LAT;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [2:0] CMD_WA = 3'b000;
  localparam logic [2:0] CMD_WD = 3'b001;
  localparam logic [2:0] CMD_RA = 3'b110;
  localparam logic [2:0] CMD_RD = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_FRM,
    S_GAP1,
    S_DATA_FRM,
    S_RD_WAIT,
    S_RD_CAP,
    S_TAIL
  } state_t;

  state_t          state, state_d;
  logic [3:0]      bit_cnt, bit_cnt_d;
  logic [CW-1:0]   gap_cnt, gap_cnt_d;
  logic [10:0]     frame_sr, frame_sr_d;
  logic            ss_n_q, ss_n_d;

  logic            cmd_wr;
  logic [7:0]      cmd_addr;
  logic [7:0]      cmd_wdata;
  logic [7:0]      cap_sr;
  logic            rsp_valid_q;
  logic [7:0]      rsp_rdata_q;

  logic            wc_valid, rc_valid;
  logic [7:0]      wc_addr, rc_addr;

  logic            accept;
  logic            cap_en;
  logic            rsp_set;
  logic            cache_upd;
  logic            hit;
  logic [10:0]     data_frame;

  // A hit means the slave already holds this address for this direction.
  assign hit = (ADDR_CACHE != 0) &&
               (req_wr ? (wc_valid && (wc_addr == req_addr))
                       : (rc_valid && (rc_addr == req_addr)));

  assign data_frame = cmd_wr ? {CMD_WD, cmd_wdata} : {CMD_RD, 8'h00};

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    gap_cnt_d  = gap_cnt;
    frame_sr_d = {frame_sr[9:0], 1'b0};
    ss_n_d     = 1'b1;
    accept     = 1'b0;
    cap_en     = 1'b0;
    rsp_set    = 1'b0;
    cache_upd  = 1'b0;

    unique case (state)
      S_IDLE: begin
        frame_sr_d = '0;
        if (req_valid) begin
          accept    = 1'b1;
          bit_cnt_d = '0;
          ss_n_d    = 1'b0;
          if (hit) begin
            state_d    = S_DATA_FRM;
            frame_sr_d = req_wr ? {CMD_WD, req_wdata} : {CMD_RD, 8'h00};
          end else begin
            state_d    = S_ADDR_FRM;
            frame_sr_d = {req_wr ? CMD_WA : CMD_RA, req_addr};
          end
        end
      end

      S_ADDR_FRM: begin
        ss_n_d    = 1'b0;
        bit_cnt_d = bit_cnt + 4'd1;
        if (bit_cnt == 4'd10) begin
          state_d   = S_GAP1;
          gap_cnt_d = '0;
          ss_n_d    = 1'b1;
          cache_upd = 1'b1;
        end
      end

      S_GAP1: begin
        gap_cnt_d = gap_cnt + CW'(1);
        if (gap_cnt == CW'(GAP - 1)) begin
          state_d    = S_DATA_FRM;
          bit_cnt_d  = '0;
          ss_n_d     = 1'b0;
          frame_sr_d = data_frame;
        end
      end

      S_DATA_FRM: begin
        ss_n_d    = 1'b0;
        bit_cnt_d = bit_cnt + 4'd1;
        if (bit_cnt == 4'd10) begin
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          if (cmd_wr) begin
            state_d = S_TAIL;
            ss_n_d  = 1'b1;
            rsp_set = 1'b1;
          end else if (RD_LAT == 0) begin
            state_d = S_RD_CAP;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end

      S_RD_WAIT: begin
        ss_n_d    = 1'b0;
        gap_cnt_d = gap_cnt + CW'(1);
        if (gap_cnt == CW'(RD_LAT - 1)) state_d = S_RD_CAP;
      end

      S_RD_CAP: begin
        ss_n_d    = 1'b0;
        cap_en    = 1'b1;
        bit_cnt_d = bit_cnt + 4'd1;
        if (bit_cnt == 4'd7) begin
          state_d   = S_TAIL;
          ss_n_d    = 1'b1;
          rsp_set   = 1'b1;
          gap_cnt_d = '0;
        end
      end

      S_TAIL: begin
        gap_cnt_d = gap_cnt + CW'(1);
        if (gap_cnt == CW'(GAP - 1)) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      frame_sr <= '0;
      ss_n_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state    <= state_d;
      bit_cnt  <= bit_cnt_d;
      gap_cnt  <= gap_cnt_d;
      frame_sr <= frame_sr_d;
      ss_n_q   <= ss_n_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wr      <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      cap_sr      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      wc_valid    <= 1'b0;
      wc_addr     <= '0;
      rc_valid    <= 1'b0;
      rc_addr     <= '0;
    end else begin
      if (accept) begin
        cmd_wr    <= req_wr;
        cmd_addr  <= req_addr;
        cmd_wdata <= req_wdata;
      end
      if (cap_en) cap_sr <= {cap_sr[6:0], MISO};
      rsp_valid_q <= rsp_set;
      if (rsp_set) rsp_rdata_q <= cmd_wr ? 8'h00 : {cap_sr[6:0], MISO};
      if (cache_upd && (ADDR_CACHE != 0)) begin
        if (cmd_wr) begin
          wc_valid <= 1'b1;
          wc_addr  <= cmd_addr;
        end else begin
          rc_valid <= 1'b1;
          rc_addr  <= cmd_addr;
        end
      end
    end
  end

  // The frame shifter drains to zero, so MOSI is already 0 outside frames.
  assign MOSI      = frame_sr[10];
  assign SS_n      = ss_n_q;
  assign req_ready = (state == S_IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: four instances (default, address cache, RD_LAT=0,
// RD_LAT=3), each with a behavioural serial RAM slave and shared scoreboards.
module tb_spi_mem_master;

  localparam int N = 4;

  logic       clk;
  logic       rst_n;
  logic       req_valid [N];
  logic       req_ready [N];
  logic       req_wr    [N];
  logic [7:0] req_addr  [N];
  logic [7:0] req_wdata [N];
  logic       rsp_valid [N];
  logic [7:0] rsp_rdata [N];
  logic       busy      [N];
  logic       mosi      [N];
  logic       ss_n      [N];
  logic       miso      [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_mem_master #(
      .GAP       (2),
      .RD_LAT    ((g == 2) ? 0 : ((g == 3) ? 3 : 1)),
      .ADDR_CACHE((g == 1) ? 1 : 0)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_wr   (req_wr[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_rdata(rsp_rdata[g]),
      .busy     (busy[g]),
      .MOSI     (mosi[g]),
      .SS_n     (ss_n[g]),
      .MISO     (miso[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          inst;
    logic [10:0] bits;
    int          start;
  } frm_t;

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         cyc;
  } rsp_t;

  frm_t frm_q [$];
  rsp_t rsp_q [$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural slave state, one set per instance.
  int          low_run  [N];
  int          high_run [N];
  int          sbits    [N];
  int          fstart   [N];
  logic [10:0] sh       [N];
  logic [7:0]  waddr    [N];
  logic [7:0]  raddr    [N];
  logic [7:0]  rbyte    [N];
  logic [7:0]  mem      [N][256];
  int          mosi_viol = 0;
  int          len_viol  = 0;
  int          gap_viol  = 0;

  function automatic int lat_of(input int i);
    return (i == 2) ? 0 : ((i == 3) ? 3 : 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance to the falling edge, then run the response monitor and
  // every slave model on the values the DUTs are presenting in this cycle.
  task automatic tick();
    rsp_t r;
    frm_t f;
    int   r_off;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (rsp_valid[i] === 1'b1) begin
        check("rsp_expected", 32'(rsp_q.size() > 0), 1);
        if (rsp_q.size() > 0) begin
          r = rsp_q.pop_front();
          check("rsp_inst", i, r.inst);
          check("rsp_cycle", cyc, r.cyc);
          check("rsp_rdata", {24'd0, rsp_rdata[i]}, {24'd0, r.data});
        end
      end

      if (ss_n[i] === 1'b1) begin
        if (mosi[i] !== 1'b0) mosi_viol++;
        if (low_run[i] > 0 && sbits[i] == 11) begin
          if (low_run[i] != ((sh[i][10:8] == 3'b111) ? 19 + lat_of(i) : 11)) len_viol++;
        end
        low_run[i] = 0;
        sbits[i]   = 0;
        high_run[i]++;
        miso[i]    = 1'b0;
      end else begin
        if (low_run[i] == 0) begin
          if (high_run[i] < 2) gap_viol++;
          fstart[i] = cyc;
        end
        low_run[i]++;
        high_run[i] = 0;
        if (sbits[i] < 11) begin
          sh[i] = {sh[i][9:0], mosi[i]};
          sbits[i]++;
          miso[i] = 1'b0;
          if (sbits[i] == 11) begin
            case (sh[i][10:8])
              3'b000:  waddr[i] = sh[i][7:0];
              3'b001:  mem[i][waddr[i]] = sh[i][7:0];
              3'b110:  raddr[i] = sh[i][7:0];
              3'b111:  rbyte[i] = mem[i][raddr[i]];
              default: ;
            endcase
            check("frame_expected", 32'(frm_q.size() > 0), 1);
            if (frm_q.size() > 0) begin
              f = frm_q.pop_front();
              check("frame_inst", i, f.inst);
              check("frame_bits", {21'd0, sh[i]}, {21'd0, f.bits});
              check("frame_start", fstart[i], f.start);
            end
          end
        end else begin
          r_off   = low_run[i] - 12 - lat_of(i);
          miso[i] = (r_off >= 0 && r_off < 8) ? rbyte[i][7 - r_off] : 1'b0;
        end
      end
    end
  endtask

  // Present a request, wait for the accepting edge, and (if push) enqueue the
  // frames and response the slave protocol timing implies.
  task automatic txn(input int i, input logic wr, input logic [7:0] addr,
                     input logic [7:0] wd, input bit hit, input bit push,
                     input bit hold, input logic [7:0] rdata,
                     output int base, output int done);
    bit   got;
    int   t;
    frm_t f;
    rsp_t r;
    got  = 1'b0;
    base = -1;
    req_valid[i] = 1'b1;
    req_wr[i]    = wr;
    req_addr[i]  = addr;
    req_wdata[i] = wd;
    for (int n = 0; n < 100 && !got; n++) begin
      if (req_ready[i] === 1'b1) begin
        got  = 1'b1;
        base = cyc;
      end
      tick();
    end
    check("accept_seen", 32'(got), 1);
    if (!hold) begin
      req_valid[i] = 1'b0;
      req_wr[i]    = 1'($urandom);
      req_addr[i]  = 8'($urandom);
      req_wdata[i] = 8'($urandom);
    end
    t = 1;
    if (!hit) begin
      f.inst  = i;
      f.bits  = {wr ? 3'b000 : 3'b110, addr};
      f.start = base + 1;
      if (push) frm_q.push_back(f);
      t = 14;
    end
    f.inst  = i;
    f.bits  = {wr ? 3'b001 : 3'b111, wr ? wd : 8'h00};
    f.start = base + t;
    r.inst  = i;
    r.data  = wr ? 8'h00 : rdata;
    r.cyc   = wr ? base + t + 11 : base + t + 11 + lat_of(i) + 8;
    done    = r.cyc + 2;
    if (push) begin
      frm_q.push_back(f);
      rsp_q.push_back(r);
    end
  endtask

  // Busy through the last tail cycle, ready exactly at ready_cyc.
  task automatic drain(input int i, input int ready_cyc);
    while (cyc < ready_cyc - 1) tick();
    check("ready_low_in_tail", 32'(req_ready[i]), 0);
    tick();
    check("ready_cycle", 32'(req_ready[i]), 1);
    check("rsp_drained", rsp_q.size(), 0);
    check("frames_drained", frm_q.size(), 0);
  endtask

  int b0, d0, b1, d1;

  initial begin
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      req_wr[i]    = 1'b0;
      req_addr[i]  = 8'h00;
      req_wdata[i] = 8'h00;
      miso[i]      = 1'b0;
      low_run[i]   = 0;
      high_run[i]  = 100;
      sbits[i]     = 0;
      fstart[i]    = 0;
      sh[i]        = '0;
      waddr[i]     = 8'h00;
      raddr[i]     = 8'h00;
      rbyte[i]     = 8'h00;
      for (int a = 0; a < 256; a++) mem[i][a] = 8'h81;
    end
    #1 rst_n = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < N; i++) begin
      check("reset_ss_n", 32'(ss_n[i]), 1);
      check("reset_mosi", 32'(mosi[i]), 0);
      check("reset_ready", 32'(req_ready[i]), 1);
      check("reset_busy", 32'(busy[i]), 0);
      check("reset_rsp_valid", 32'(rsp_valid[i]), 0);
      check("reset_rsp_rdata", {24'd0, rsp_rdata[i]}, 0);
    end
    rst_n = 1'b1;
    tick();

    // Reset in cycle 5 of an address frame: immediate idle pins, no response.
    txn(0, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, b0, d0);
    while (cyc < b0 + 5) tick();
    check("midframe_ss_low", 32'(ss_n[0]), 0);
    rst_n = 1'b0;
    #1;
    check("abort_ss_n", 32'(ss_n[0]), 1);
    check("abort_mosi", 32'(mosi[0]), 0);
    check("abort_ready", 32'(req_ready[0]), 1);
    check("abort_rsp_valid", 32'(rsp_valid[0]), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("abort_ready_after_release", 32'(req_ready[0]), 1);
    repeat (30) tick();

    // Write then read back on the default instance.
    txn(0, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h00, b0, d0);
    drain(0, d0);
    check("write_ready_at_27", d0 - b0, 27);
    txn(0, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, b0, d0);
    drain(0, d0);
    check("read_ready_at_36", d0 - b0, 36);

    // Back-to-back with req_valid held high across the first transaction.
    txn(0, 1'b1, 8'h10, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h00, b0, d0);
    txn(0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 8'hFF, b1, d1);
    check("b2b_second_accept", b1 - b0, 27);
    drain(0, d1);

    // Address cache: repeat read skips the address frame, new address does not.
    txn(1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b1, 1'b0, 8'h81, b0, d0);
    drain(1, d0);
    txn(1, 1'b0, 8'h22, 8'h00, 1'b1, 1'b1, 1'b0, 8'h81, b0, d0);
    drain(1, d0);
    txn(1, 1'b0, 8'h23, 8'h00, 1'b0, 1'b1, 1'b0, 8'h81, b0, d0);
    drain(1, d0);

    // Read latency extremes.
    txn(2, 1'b0, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 8'h81, b0, d0);
    drain(2, d0);
    txn(3, 1'b0, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 8'h81, b0, d0);
    drain(3, d0);

    repeat (5) tick();
    check("mosi_zero_when_deselected", mosi_viol, 0);
    check("frame_lengths", len_viol, 0);
    check("inter_frame_gaps", gap_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_mem_master.md
Name: spi_mem_master

Overview:
- Host-side controller that sequences the serial RAM slave (MOSI/SS_n/MISO, shared clk).
- Turns parallel host requests (write byte / read byte at 8-bit address) into the 2-frame slave protocol: address frame, then data frame.
- For reads, captures the returned byte.
- Sits between on-chip requesters (valid/ready) and the slave pins; single outstanding request.

Parameters:
- GAP, 2: SS_n-high cycles between frames and after the final frame; minimum 1.
- RD_LAT, 1: cycles after the read-data frame, SS_n held low, before the first MISO bit is valid; minimum 0.
- ADDR_CACHE, 0: 1 enables skipping the address frame when the address is unchanged.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  host request valid
- req_ready  out  1  controller idle, request accepted when valid&ready
- req_wr  in  1  1=write, 0=read
- req_addr  in  8  target address
- req_wdata  in  8  write data (ignored for reads)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read byte (0 for writes), valid with rsp_valid
- busy  out  1  ~req_ready
- MOSI  out  1  serial data to slave, MSB first
- SS_n  out  1  slave select, active low
- MISO  in  1  serial data from slave

Behaviour:
- Reset (async, any time incl. mid-frame):
  - Outputs: SS_n=1, MOSI=0, req_ready=1, rsp_valid=0, rsp_rdata=0.
  - FSM to IDLE, counters cleared, address cache invalidated.
  - The aborted request produces no response.
- Frame format: 11 bits, one bit per clk, registered outputs, MSB first: 3 cmd bits then 8 payload bits.
  - Write-address cmd 000, payload = addr.
  - Write-data cmd 001, payload = wdata.
  - Read-address cmd 110, payload = addr.
  - Read-data cmd 111, payload = 8 dummy zeros.
- SS_n low for exactly the 11 frame cycles (plus read extension); MOSI=0 whenever SS_n=1.
- FSM states: IDLE -> ADDR_FRM -> GAP1 -> DATA_FRM -> (write: TAIL) / (read: RD_WAIT -> RD_CAP -> TAIL) -> IDLE.
  - 4-bit bit counter; gap/latency counter sized for max(GAP, RD_LAT).
- Accept:
  - req_ready=1 only in IDLE; the accepting edge latches req_wr/addr/wdata.
  - Inputs are don't-care after acceptance.
- Write timing, GAP=2, accept edge ends cycle 0:
  - ADDR_FRM cycles 1-11.
  - GAP1 cycles 12-13.
  - DATA_FRM cycles 14-24.
  - TAIL cycles 25-26, with rsp_valid=1 in cycle 25.
  - req_ready=1 from cycle 27.
- Read timing, GAP=2, RD_LAT=1:
  - Address frame 110 cycles 1-11, gap 12-13, data frame 111 cycles 14-24.
  - SS_n stays low through RD_WAIT (cycle 25) and RD_CAP (cycles 26-33).
  - MISO sampled at the end of each RD_CAP cycle, first sample = bit7.
  - SS_n=1 from cycle 34; rsp_valid and rsp_rdata in cycle 34; req_ready from cycle 36.
- rsp_rdata holds its last value until the next rsp_valid; rsp_valid is never back-pressured.
- Address cache (ADDR_CACHE=1):
  - Separate write-address and read-address cache registers, each with a valid flag.
  - A cache register is updated when its address frame completes.
  - If the request address matches the valid cache for its direction, ADDR_FRM and GAP1 are skipped and DATA_FRM starts in cycle 1.
  - With ADDR_CACHE=0, both frames are always sent.
- req_valid asserted while busy: ignored and not queued; the host must hold it until accepted.
- Back-to-back requests: the next accept occurs at the earliest in the first IDLE cycle. SS_n is therefore high for ≥GAP cycles between any two frames.

Test Plan:
- Reset mid-ADDR_FRM (assert rst_n=0 in cycle 5) -> SS_n=1, MOSI=0 immediately; no rsp_valid; req_ready=1 after release.
- Write addr=0xA5 data=0x3C, GAP=2 -> MOSI bits cycles 1-11 = 000_10100101; SS_n high 12-13; cycles 14-24 = 001_00111100; rsp_valid in cycle 25, rsp_rdata=0; req_ready at cycle 27.
- Read addr=0xA5 after that write, with a behavioural slave returning the stored byte -> frames 110_10100101 and 111_00000000; rsp_rdata=0x3C in cycle 34.
- Back-to-back: write 0x10/0xFF then read 0x10 with req_valid held high -> second accept in cycle 27; SS_n high ≥2 cycles between all frames; read returns 0xFF.
- ADDR_CACHE=1: two reads of 0x22, then a read of 0x23 -> second read has no address frame and rsp_valid in cycle 21; third read sends address frame 110_00100011.
- RD_LAT=0 and RD_LAT=3 with a slave driving 0x81 -> capture begins the cycle after the data frame / 3 cycles later; rsp_rdata=0x81 both times.
